// File: rtl/mul_tree_pkg.sv
// Shared definitions for the bf16 multiplier tree: lane geometry, tree modes,
// per-mode lane masks and the result-buffer entry layout.
package mul_tree_pkg;

    localparam int BF16_W = 16;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        MODE_2222 = 2'b00,
        MODE_44   = 2'b01,
        MODE_62   = 2'b10,
        MODE_8    = 2'b11
    } mode_e;

    typedef struct packed {
        logic              last;
        logic [1:0]        lane;
        logic [BF16_W-1:0] data;
    } entry_t;

    // Lanes that carry a real result in each tree configuration.
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] mode);
        logic [LANES-1:0] m;
        case (mode_e'(mode))
            MODE_2222: m = 4'b1111;
            MODE_44:   m = 4'b0011;
            MODE_62:   m = 4'b0011;
            MODE_8:    m = 4'b0001;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lane_compact4.sv
// Packs strobed lanes into consecutive entries in lane order, stopping at the
// free-slot limit; lanes past the limit are counted as drops.
module lane_compact4
    import mul_tree_pkg::*;
(
    input  logic [LANES-1:0]        stb_i,
    input  logic [LANES*BF16_W-1:0] data_i,
    input  logic [2:0]              free_lim_i,
    output entry_t [LANES-1:0]      ent_o,
    output logic [2:0]              wr_n_o,
    output logic [2:0]              drop_n_o
);

    always_comb begin
        ent_o    = '0;
        wr_n_o   = 3'd0;
        drop_n_o = 3'd0;
        for (int k = 0; k < LANES; k++) begin
            if (stb_i[k]) begin
                if (wr_n_o < free_lim_i) begin
                    ent_o[wr_n_o[1:0]].last = 1'b0;
                    ent_o[wr_n_o[1:0]].lane = 2'(k);
                    ent_o[wr_n_o[1:0]].data = data_i[BF16_W*k +: BF16_W];
                    wr_n_o = wr_n_o + 3'd1;
                end else begin
                    drop_n_o = drop_n_o + 3'd1;
                end
            end
        end
        // The last flag marks the highest lane actually written, not strobed.
        if (wr_n_o != 3'd0) begin
            ent_o[wr_n_o[1:0] - 2'd1].last = 1'b1;
        end
    end

endmodule

// File: rtl/mul_tree_result_drain.sv
// Result drain for the bf16 multiplier tree: up to four captures per cycle into
// a circular buffer, one-per-cycle FWFT output, drop accounting and issue credit.
module mul_tree_result_drain
    import mul_tree_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int SLACK = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*BF16_W-1:0] res_data,
    input  logic [LANES-1:0]        res_stb,
    input  logic [1:0]              mode,
    output logic [BF16_W-1:0]       out_data,
    output logic [1:0]              out_lane,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    can_issue,
    output logic                    overflow,
    output logic [7:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] SLACK_C = (AW+1)'(SLACK);
    localparam logic [AW:0] LANES_C = (AW+1)'(LANES);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            can_issue_q, can_issue_d;

    logic [LANES-1:0]  eff_stb;
    logic [AW:0]       free_slots;
    logic [2:0]        free_lim;
    entry_t [LANES-1:0] ent;
    logic [2:0]        wr_n;
    logic [2:0]        drop_n;
    logic              pop;
    logic [8:0]        drop_sum;
    entry_t            head;

    assign eff_stb = res_stb & lane_mask(mode);

    // Room comes from the count at the start of the cycle; a same-cycle pop
    // does not free a slot for this cycle's captures.
    assign free_slots = DEPTH_C - count_q;
    assign free_lim   = (free_slots >= LANES_C) ? 3'(LANES) : free_slots[2:0];

    lane_compact4 u_compact (
        .stb_i      (eff_stb),
        .data_i     (res_data),
        .free_lim_i (free_lim),
        .ent_o      (ent),
        .wr_n_o     (wr_n),
        .drop_n_o   (drop_n)
    );

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(wr_n);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + (AW+1)'(wr_n) - (AW+1)'(pop);
        overflow_d  = overflow_q | (drop_n != 3'd0);
        drop_sum    = {1'b0, drop_cnt_q} + 9'(drop_n);
        drop_cnt_d  = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        can_issue_d = (DEPTH_C - count_d) >= SLACK_C;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
            can_issue_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            can_issue_q <= can_issue_d;
        end
    end

    // Storage is deliberately not reset; pointer wrap handles straddling writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) begin
                if (3'(k) < wr_n) begin
                    mem_q[wr_ptr_q + AW'(k)] <= ent[k];
                end
            end
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_data  = head.data;
    assign out_lane  = head.lane;
    assign out_last  = head.last;
    assign can_issue = can_issue_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mul_tree_result_drain.sv
// Bench for mul_tree_result_drain: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_mul_tree_result_drain;

    localparam int DEPTH = 64;
    localparam int SLACK = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] res_data = '0;
    logic [3:0]  res_stb = '0;
    logic [1:0]  mode = '0;
    logic [15:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        can_issue;
    logic        overflow;
    logic [7:0]  drop_cnt;

    mul_tree_result_drain #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_data  (res_data),
        .res_stb   (res_stb),
        .mode      (mode),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .can_issue (can_issue),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        last;
        logic [1:0]  lane;
        logic [15:0] data;
    } mdl_ent_t;

    mdl_ent_t q[$];
    int       m_drops = 0;
    bit       m_ovf   = 1'b0;
    bit       m_ci    = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].data));
            chk("out_lane", 32'(out_lane), 32'(q[0].lane));
            chk("out_last", 32'(out_last), 32'(q[0].last));
        end
        chk("can_issue", 32'(can_issue), 32'(m_ci));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    endtask

    task automatic model_step(input logic r, input logic [1:0] m, input logic [3:0] s,
                              input logic [63:0] d, input logic rdy);
        int       free;
        int       nw;
        bit       popped;
        logic [3:0] mask;
        int       lanes[$];
        mdl_ent_t e;
        if (!r) begin
            q.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
            m_ci    = 1'b1;
            return;
        end
        free   = DEPTH - q.size();
        popped = (q.size() != 0) && rdy;
        case (m)
            2'b00:   mask = 4'b1111;
            2'b01:   mask = 4'b0011;
            2'b10:   mask = 4'b0011;
            default: mask = 4'b0001;
        endcase
        for (int k = 0; k < 4; k++)
            if (s[k] && mask[k]) lanes.push_back(k);
        nw = (lanes.size() < free) ? lanes.size() : free;
        if (popped) void'(q.pop_front());
        for (int i = 0; i < nw; i++) begin
            e.lane = 2'(lanes[i]);
            e.data = d[16*lanes[i] +: 16];
            e.last = (i == nw - 1);
            q.push_back(e);
        end
        if (lanes.size() > nw) begin
            m_ovf   = 1'b1;
            m_drops = m_drops + lanes.size() - nw;
            if (m_drops > 255) m_drops = 255;
        end
        m_ci = (DEPTH - q.size()) >= SLACK;
    endtask

    task automatic cycle(input logic r, input logic [1:0] m, input logic [3:0] s,
                         input logic [63:0] d, input logic rdy);
        rst       = r;
        mode      = m;
        res_stb   = s;
        res_data  = d;
        out_ready = rdy;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step(r, m, s, d, rdy);
        #1;
    endtask

    task automatic drain(output int beats);
        beats = 0;
        for (int i = 0; i < 100; i++) begin
            if (!out_valid) break;
            beats++;
            cycle(1'b1, 2'b00, 4'b0000, rnd64(), 1'b1);
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int beats;
        int rdy_pct;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ci", 32'(can_issue), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // four lanes in one cycle, read back in lane order
        cycle(1'b1, 2'b00, 4'b1111, 64'h4080_4040_4000_3F80, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_lane", 32'(out_lane), 32'(i));
            chk("t1_last", 32'(out_last), 32'(i == 3));
            cycle(1'b1, 2'b00, 4'b0000, rnd64(), 1'b1);
        end
        chk("t1_empty", 32'(out_valid), 32'd0);

        // mode 8: only lane 0 counts, masked lanes are not drops
        cycle(1'b1, 2'b11, 4'b1111, {rnd64() >> 16, 16'h4120}, 1'b1);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_data", 32'(out_data), 32'h4120);
        chk("t2_lane", 32'(out_lane), 32'd0);
        chk("t2_last", 32'(out_last), 32'd1);
        cycle(1'b1, 2'b00, 4'b0000, rnd64(), 1'b1);
        chk("t2_empty", 32'(out_valid), 32'd0);
        chk("t2_drop", 32'(drop_cnt), 32'd0);

        // fill to full, then one cycle drops all four
        cycle(1'b0, 2'b00, 4'b1111, rnd64(), 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 2'b00, 4'b1111, rnd64(), 1'b0);
        chk("t3_full_valid", 32'(out_valid), 32'd1);
        chk("t3_full_ci", 32'(can_issue), 32'd0);
        chk("t3_full_drop", 32'(drop_cnt), 32'd0);
        cycle(1'b1, 2'b00, 4'b1111, rnd64(), 1'b0);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_drop", 32'(drop_cnt), 32'd4);
        drain(beats);
        chk("t3_beats", 32'(beats), 32'd64);

        // count 62, four strobes plus a pop: two written, two dropped
        cycle(1'b0, 2'b00, 4'b0000, rnd64(), 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b1, 2'b00, 4'b1111, rnd64(), 1'b0);
        cycle(1'b1, 2'b01, 4'b0011, rnd64(), 1'b0);
        cycle(1'b1, 2'b00, 4'b1111, rnd64(), 1'b1);
        chk("t4_drop", 32'(drop_cnt), 32'd2);
        chk("t4_ovf", 32'(overflow), 32'd1);
        drain(beats);
        chk("t4_beats", 32'(beats), 32'd63);

        // write straddling the pointer wrap (slots 62,63,0,1)
        cycle(1'b0, 2'b00, 4'b0000, rnd64(), 1'b0);
        for (int i = 0; i < 15; i++) cycle(1'b1, 2'b00, 4'b1111, rnd64(), 1'b0);
        cycle(1'b1, 2'b01, 4'b0011, rnd64(), 1'b0);
        drain(beats);
        chk("t5_pre_beats", 32'(beats), 32'd62);
        cycle(1'b1, 2'b00, 4'b1111, 64'h1234_5678_9ABC_DEF0, 1'b1);
        drain(beats);
        chk("t5_wrap_beats", 32'(beats), 32'd4);

        // issue credit threshold at count 25 / 24
        cycle(1'b0, 2'b00, 4'b0000, rnd64(), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 2'b00, 4'b1111, rnd64(), 1'b0);
        chk("t6_ci_24", 32'(can_issue), 32'd1);
        cycle(1'b1, 2'b11, 4'b0001, rnd64(), 1'b0);
        chk("t6_ci_25", 32'(can_issue), 32'd0);
        cycle(1'b1, 2'b00, 4'b0000, rnd64(), 1'b1);
        chk("t6_ci_back", 32'(can_issue), 32'd1);
        cycle(1'b1, 2'b00, 4'b1111, rnd64(), 1'b0);
        cycle(1'b1, 2'b01, 4'b0011, rnd64(), 1'b0);
        chk("t6_ci_30", 32'(can_issue), 32'd0);
        cycle(1'b0, 2'b00, 4'b1111, rnd64(), 1'b1);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_ci", 32'(can_issue), 32'd1);

        // drop counter saturation
        for (int i = 0; i < 100; i++) cycle(1'b1, 2'b00, 4'b1111, rnd64(), 1'b0);
        chk("t7_sat", 32'(drop_cnt), 32'd255);
        cycle(1'b0, 2'b00, 4'b0000, rnd64(), 1'b0);

        // randomized traffic with varying consumer pressure
        rdy_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0:       rdy_pct = 10;
                    1:       rdy_pct = 30;
                    2:       rdy_pct = 60;
                    default: rdy_pct = 100;
                endcase
            end
            cycle(($urandom_range(0, 499) != 0),
                  2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)),
                  rnd64(),
                  ($urandom_range(0, 99) < rdy_pct));
        end
        drain(beats);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
